// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared sizes, state encoding and selection helpers for the obstacle bank
package obstacle_pkg;
  localparam int N_OBSTACLES = 8;
  localparam int SEL_W = 3;
  localparam int OBST_BUS_W = 36;
  localparam logic [7:0] DEFAULT_LFSR_SEED = 8'hA5;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t PICK = 3'd1;
  localparam state_t RUN  = 3'd2;
  localparam state_t GAP  = 3'd3;
  localparam state_t STOP = 3'd4;
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] rgb;
  } obst_bus_t;
  function automatic logic [N_OBSTACLES-1:0] onehot(input logic [SEL_W-1:0] sel);
    return N_OBSTACLES'(1) << sel;
  endfunction
  function automatic logic [SEL_W-1:0] no_repeat(input logic [SEL_W-1:0] cand, input logic [SEL_W-1:0] prev);
    return cand == prev ? cand + 1'b1 : cand;
  endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR with seed load, single-step enable and low bits of the next value
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5,
  parameter int RND_W = 3
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [RND_W-1:0] rnd
);
  logic [7:0] value, value_next;
  assign value_next = {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
  assign rnd = value_next[RND_W-1:0];
  always_ff @(posedge pclk)
    if (rst || load) value <= SEED;
    else if (step) value <= value_next;
endmodule

// File: rtl/obstacle_sequencer.sv
// obstacle_sequencer: picks and times the active obstacle, driving the mux select and one-hot enables
module obstacle_sequencer
  import obstacle_pkg::*;
#(
  parameter int MAX_FRAMES = 600,
  parameter int GAP_FRAMES = 60,
  parameter logic [7:0] LFSR_SEED = DEFAULT_LFSR_SEED,
  parameter int CNT_W = 10
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   game_over,
  input  logic                   frame_tick,
  input  logic                   obstacle_done,
  output logic [SEL_W-1:0]       select,
  output logic [N_OBSTACLES-1:0] obstacle_en,
  output logic                   busy,
  output logic [7:0]             obstacle_cnt
);
  state_t state, state_nx;
  logic [CNT_W-1:0] frame_cnt, frame_nx;
  logic [SEL_W-1:0] select_nx, cand;
  logic [N_OBSTACLES-1:0] en_nx;
  logic busy_nx;
  logic [7:0] cnt_nx;
  logic go, pick, finish, last_gap;
  assign go = start && !game_over && (state == IDLE || state == STOP);
  assign pick = state == PICK && !game_over;
  assign finish = state == RUN && !game_over &&
                  (obstacle_done || (frame_tick && frame_cnt == CNT_W'(MAX_FRAMES - 1)));
  assign last_gap = frame_tick && frame_cnt == CNT_W'(GAP_FRAMES - 1);
  lfsr8 #(.SEED(LFSR_SEED), .RND_W(SEL_W)) u_lfsr (
    .pclk (pclk),
    .rst  (rst),
    .load (go),
    .step (pick),
    .rnd  (cand)
  );
  always_ff @(posedge pclk)
    if (rst) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      select       <= '0;
      obstacle_en  <= '0;
      busy         <= 1'b0;
      obstacle_cnt <= '0;
    end else begin
      state        <= state_nx;
      frame_cnt    <= frame_nx;
      select       <= select_nx;
      obstacle_en  <= en_nx;
      busy         <= busy_nx;
      obstacle_cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    if (game_over) state_nx = state == IDLE ? IDLE : STOP;
    else if (go) state_nx = PICK;
    else if (state == PICK) state_nx = RUN;
    else if (finish) state_nx = GAP;
    else if (state == GAP && last_gap) state_nx = PICK;
  end
  always_comb begin
    select_nx = pick ? no_repeat(cand, select) : select;
    en_nx = pick ? onehot(select_nx) : state_nx == RUN ? obstacle_en : '0;
    busy_nx = state_nx inside {PICK, RUN, GAP};
    cnt_nx = go ? '0 : (finish && obstacle_cnt != 8'hFF) ? obstacle_cnt + 1'b1 : obstacle_cnt;
    frame_nx = (state_nx == state && (state == RUN || state == GAP)) ? frame_cnt + CNT_W'(frame_tick) : '0;
  end
endmodule

// File: doc/obstacle_sequencer.md
Name: obstacle_sequencer

Overview:
- Control-side counterpart of the 8-input obstacle mux. It decides which of the 8 obstacle generators is active.
- Drives the mux `select` and a one-hot enable to the obstacle modules, and sequences them through a game.
- Selection is pseudo-random (8-bit LFSR) with a no-immediate-repeat rule. Each obstacle has a completion-or-timeout dwell, followed by an inter-obstacle gap measured in frames.
- Sits between the game-state logic (start/game_over) and the obstacle bank feeding the mux.

Parameters:
- MAX_FRAMES, 600, frame ticks an obstacle may stay active before forced timeout (10 s at 60 Hz).
- GAP_FRAMES, 60, frame ticks of blank gap between obstacles.
- LFSR_SEED, 8'hA5, LFSR value loaded on reset and on every start; must be non-zero.
- CNT_W, 10, width of the frame counter; must hold max(MAX_FRAMES, GAP_FRAMES).

Ports:
- pclk  in  1  pixel clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a game.
- game_over  in  1  level; forces the block to STOP.
- frame_tick  in  1  one-cycle pulse per frame (end of vsync).
- obstacle_done  in  1  one-cycle pulse from the active obstacle when it finishes.
- select  out  3  index to the obstacle mux.
- obstacle_en  out  8  one-hot enable of the active obstacle; all zero when none is active.
- busy  out  1  high in PICK/RUN/GAP.
- obstacle_cnt  out  8  number of obstacles completed this game; saturates at 255.

Behaviour:
- All outputs are registered. Reset values: select=0, obstacle_en=0, busy=0, obstacle_cnt=0. Internal state: state=IDLE, lfsr=LFSR_SEED, frame_cnt=0.
- LFSR:
  - Fibonacci form, left shift: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Steps exactly once per PICK cycle and never otherwise.
  - Reloads LFSR_SEED on start.
- Candidate index: cand = next[2:0]. If cand == current select, use cand+1 (mod 8) instead, so the same obstacle never appears twice in a row.
- States:
  - IDLE: obstacle_en=0, busy=0. On start: clear obstacle_cnt, reload LFSR, go to PICK.
  - PICK: exactly one cycle. Step the LFSR, register select and obstacle_en=1<<select in the same edge, clear frame_cnt, go to RUN. obstacle_en and select are valid together from the cycle after PICK.
  - RUN:
    - frame_cnt increments on each frame_tick.
    - On obstacle_done, or on a frame_tick where frame_cnt==MAX_FRAMES-1: obstacle_en=0, obstacle_cnt+1 (saturating), frame_cnt=0, go to GAP.
    - If obstacle_done and the timeout tick occur in the same cycle, count once.
    - select holds its value through GAP, so mux output stays stable.
  - GAP: obstacle_en=0; frame_cnt increments on frame_tick. On the tick where frame_cnt==GAP_FRAMES-1, go to PICK.
  - STOP: entered from any state except IDLE when game_over=1. obstacle_en=0, busy=0, obstacle_cnt frozen. Leaves to PICK on start (after clear and reload); start has priority over a still-high game_over only if game_over has dropped.
- Priority per cycle: rst > game_over > start > obstacle_done > frame_tick.
- start in PICK/RUN/GAP is ignored.
- obstacle_done outside RUN is ignored.
- A GAP_FRAMES value of 0 is illegal. MAX_FRAMES=1 means the obstacle times out on the first tick.
- rst mid-RUN: outputs return to reset values on the next edge and no done is counted.

Decomposition:
- Shared package (obstacle_pkg):
  - N_OBSTACLES=8, SEL_W=3, OBST_BUS_W=36 ({x[11:0], y[11:0], rgb[11:0]}).
  - State encoding localparams IDLE/PICK/RUN/GAP/STOP.
  - Default LFSR_SEED.
- One natural sub-module: lfsr8 (seed load, step enable, next-value output), reusable for other randomised game elements.
- The rest is one FSM plus the frame counter.

Test Plan:
- rst, then start with default seed → one cycle in PICK; next cycle select=2, obstacle_en=8'b0000_0100, busy=1.
- In RUN, pulse obstacle_done after 5 frame_ticks → obstacle_en=0 next cycle, obstacle_cnt=1; after exactly 60 further ticks, a new PICK occurs with select≠2.
- No obstacle_done; 600 frame_ticks → timeout on the 600th tick, obstacle_cnt=1. obstacle_done and the 600th tick in the same cycle → obstacle_cnt=1, not 2.
- Force the LFSR so cand equals the current select (for example, preload so next[2:0]=select=5) → select=6.
- game_over asserted mid-RUN → next cycle obstacle_en=0, busy=0, obstacle_cnt held. After game_over drops, start → obstacle_cnt=0 and first select=2 again (seed reloaded).
- rst asserted in GAP, plus a start pulse while busy and an obstacle_done in GAP → all outputs return to reset values; the ignored pulses cause no state or count change.
